// File: rtl/mem_port_hs_if.sv
// Request/response handshake bundle between a load/store client
// and the simulated-memory port.
interface mem_port_hs_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_rw, req_addr, req_len, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_len, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_port_hs.sv
// Valid/ready memory port with programmable latency and size/alignment
// checking; the backing store is reached through a one-shot access strobe.
module mem_port_hs #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int LATENCY     = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_hs_if.slave      bus,
    output logic              busy,
    output logic              vmem_en,
    output logic              vmem_rw,
    output logic [ADDR_W-1:0] vmem_addr,
    output logic [3:0]        vmem_len,
    output logic [DATA_W-1:0] vmem_wdata,
    input  logic [DATA_W-1:0] vmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              rdy_q;
    logic              vld_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              len_ok;
    logic              mis;
    logic              err;
    logic              accept;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] rdata_m;

    always_comb begin
        len_ok = 1'b0;
        case (bus.req_len)
            4'd1, 4'd2, 4'd4: len_ok = 1'b1;
            4'd8:             len_ok = (DATA_W == 64);
            default:          len_ok = 1'b0;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (i < int'(bus.req_len)) mask[i*8 +: 8] = 8'hFF;
        end
    end

    // Alignment only matters once the size itself is legal.
    assign mis = (ALIGN_CHECK != 0) && len_ok &&
                 (|(bus.req_addr[3:0] & (bus.req_len - 4'd1)));
    assign err = !len_ok || mis;

    // Ready is forced low while reset is held.
    assign bus.req_ready = rdy_q & reset;
    assign accept        = bus.req_valid & rdy_q & reset;

    assign vmem_en    = accept & ~err;
    assign vmem_rw    = bus.req_rw;
    assign vmem_addr  = bus.req_addr;
    assign vmem_len   = bus.req_len;
    assign vmem_wdata = bus.req_wdata & mask;
    assign rdata_m    = vmem_rdata & mask;

    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rdy_q   <= 1'b0;
                        busy    <= 1'b1;
                        err_q   <= err;
                        rdata_q <= (err || bus.req_rw) ? '0 : rdata_m;
                        cnt     <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state <= RESP;
                            vld_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        vld_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state   <= IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        busy    <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_hs.sv
// Bench for mem_port_hs: three ports at latencies 1, 5 and 4 share one
// byte-array backing store that counts every access strobe.
module tb_mem_port_hs;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [63:0] req_addr = '0;
    logic [3:0]  req_len = 4'd0;
    logic [63:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        rdy_a   [3];
    logic        vld_a   [3];
    logic        err_a   [3];
    logic        busy_a  [3];
    logic [63:0] rdata_a [3];
    logic        en_a    [3];
    logic        rw_a    [3];
    logic [63:0] addr_a  [3];
    logic [3:0]  len_a   [3];
    logic [63:0] wd_a    [3];

    logic [7:0]  cmem [256];
    int          dpi_calls = 0;
    logic [7:0]  ref_mem [logic [63:0]];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        logic [63:0] rd;
        logic        er;
        int          calls;
        bit          ok;
        bit          stable;
        bit          rdy_low;
        bit          rdy_after;
        bit          vld_after;
    } res_t;

    for (genvar g = 0; g < 3; g++) begin : g_port
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 5 : 4;
        mem_port_hs_if #(.ADDR_W(64), .DATA_W(64)) bus ();
        logic [63:0] vrd;

        assign bus.req_valid = req_valid && (sel == g);
        assign bus.req_rw    = req_rw;
        assign bus.req_addr  = req_addr;
        assign bus.req_len   = req_len;
        assign bus.req_wdata = req_wdata;
        assign bus.rsp_ready = rsp_ready && (sel == g);

        assign rdy_a[g]   = bus.req_ready;
        assign vld_a[g]   = bus.rsp_valid;
        assign err_a[g]   = bus.rsp_err;
        assign rdata_a[g] = bus.rsp_rdata;

        always_comb begin
            vrd = '0;
            for (int b = 0; b < 8; b++)
                vrd[b*8 +: 8] = cmem[8'(addr_a[g][7:0] + 8'(b))];
        end

        mem_port_hs #(
            .ADDR_W(64), .DATA_W(64), .LATENCY(LAT), .ALIGN_CHECK(1)
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .bus        (bus),
            .busy       (busy_a[g]),
            .vmem_en    (en_a[g]),
            .vmem_rw    (rw_a[g]),
            .vmem_addr  (addr_a[g]),
            .vmem_len   (len_a[g]),
            .vmem_wdata (wd_a[g]),
            .vmem_rdata (vrd)
        );
    end

    // Simulated C-side memory: little-endian, counts each access.
    always @(posedge clock) begin
        for (int g = 0; g < 3; g++) begin
            if (en_a[g]) begin
                dpi_calls <= dpi_calls + 1;
                if (rw_a[g])
                    for (int b = 0; b < int'(len_a[g]); b++)
                        cmem[8'(addr_a[g][7:0] + 8'(b))] <= wd_a[g][b*8 +: 8];
            end
        end
    end

    function automatic bit ref_err(input logic [63:0] a, input int len);
        if (!(len inside {1, 2, 4, 8})) return 1'b1;
        return (a % 64'(len)) != 0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a, input int len);
        logic [63:0] v;
        v = '0;
        for (int b = len - 1; b >= 0; b--) v = (v << 8) | 64'(ref_byte(a + 64'(b)));
        return v;
    endfunction

    function automatic void ref_write(input logic [63:0] a, input int len,
                                      input logic [63:0] wd);
        for (int b = 0; b < len; b++) ref_mem[a + 64'(b)] = 8'(wd >> (8 * b));
    endfunction

    task automatic run(input int g, input bit rw, input logic [63:0] addr,
                       input logic [3:0] len, input logic [63:0] wd,
                       input int stall, output res_t r);
        int n;
        int c0;
        logic [63:0] d0;
        logic e0;
        r.lat = 0; r.rd = '0; r.er = 1'b0; r.calls = 0; r.ok = 1'b0;
        r.stable = 1'b0; r.rdy_low = 1'b0; r.rdy_after = 1'b0; r.vld_after = 1'b0;
        sel = g;
        @(negedge clock);
        req_valid = 1'b1; req_rw = rw; req_addr = addr;
        req_len = len; req_wdata = wd; rsp_ready = 1'b0;
        c0 = dpi_calls;
        n = 0;
        while (!rdy_a[g] && n < 64) begin @(negedge clock); n++; end
        if (!rdy_a[g]) begin req_valid = 1'b0; return; end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        r.rdy_low = 1'b1;
        r.lat = 1;
        while (!vld_a[g] && r.lat < 40) begin
            if (rdy_a[g]) r.rdy_low = 1'b0;
            @(negedge clock);
            r.lat++;
        end
        if (!vld_a[g]) return;
        d0 = rdata_a[g]; e0 = err_a[g]; r.stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            if (rdy_a[g]) r.rdy_low = 1'b0;
            @(negedge clock);
            if (rdata_a[g] !== d0 || err_a[g] !== e0 || vld_a[g] !== 1'b1) r.stable = 1'b0;
        end
        if (rdy_a[g]) r.rdy_low = 1'b0;
        r.rd = d0; r.er = e0;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        r.rdy_after = rdy_a[g];
        r.vld_after = vld_a[g];
        r.calls = dpi_calls - c0;
        r.ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({rdy_a[g], vld_a[g], err_a[g], busy_a[g]} !== 4'b0000 || rdata_a[g] !== 64'd0) begin
                errors++;
                $display("FAIL reset_outputs port%0d: rdy=%b vld=%b err=%b busy=%b rdata=%h, required all 0",
                         g, rdy_a[g], vld_a[g], err_a[g], busy_a[g], rdata_a[g]);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (rdy_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", rdy_a[0], busy_a[0]);
        end
        checks++;
        if (dpi_calls !== 0) begin
            errors++;
            $display("FAIL reset_no_calls: calls=%0d, required 0", dpi_calls);
        end
    endtask

    task automatic test_write_read();
        res_t r;
        run(0, 1'b1, 64'h8000_0000, 4'd8, 64'h1122334455667788, 0, r);
        ref_write(64'h8000_0000, 8, 64'h1122334455667788);
        checks++;
        if (!r.ok || r.lat != 1 || r.er !== 1'b0 || r.rd !== 64'd0 || r.calls != 1) begin
            errors++;
            $display("FAIL write8: ok=%0d lat=%0d err=%b rdata=%h calls=%0d, required 1 1 0 0 1",
                     r.ok, r.lat, r.er, r.rd, r.calls);
        end
        run(0, 1'b0, 64'h8000_0000, 4'd8, 64'h0, 0, r);
        checks++;
        if (!r.ok || r.lat != 1 || r.er !== 1'b0 || r.rd !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL read8: ok=%0d lat=%0d err=%b rdata=%h, required lat 1 err 0 rdata 1122334455667788",
                     r.ok, r.lat, r.er, r.rd);
        end
    endtask

    task automatic test_narrow_read();
        res_t r;
        run(0, 1'b0, 64'h8000_0003, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, r);
        checks++;
        if (!r.ok || r.er !== 1'b0 || r.rd !== 64'h55) begin
            errors++;
            $display("FAIL read_byte: ok=%0d err=%b rdata=%h, required err 0 rdata 55", r.ok, r.er, r.rd);
        end
        run(0, 1'b0, 64'h8000_0004, 4'd2, 64'h0, 0, r);
        checks++;
        if (!r.ok || r.er !== 1'b0 || r.rd !== 64'h3344) begin
            errors++;
            $display("FAIL read_half: ok=%0d err=%b rdata=%h, required err 0 rdata 3344", r.ok, r.er, r.rd);
        end
    endtask

    task automatic test_errors();
        res_t r;
        run(0, 1'b0, 64'h8000_0002, 4'd4, 64'h0, 0, r);
        checks++;
        if (!r.ok || r.er !== 1'b1 || r.rd !== 64'd0 || r.calls != 0) begin
            errors++;
            $display("FAIL misaligned: ok=%0d err=%b rdata=%h calls=%0d, required err 1 rdata 0 calls 0",
                     r.ok, r.er, r.rd, r.calls);
        end
        run(0, 1'b1, 64'h8000_0000, 4'd3, 64'hDEAD_BEEF, 0, r);
        checks++;
        if (!r.ok || r.er !== 1'b1 || r.rd !== 64'd0 || r.calls != 0) begin
            errors++;
            $display("FAIL bad_size: ok=%0d err=%b rdata=%h calls=%0d, required err 1 rdata 0 calls 0",
                     r.ok, r.er, r.rd, r.calls);
        end
        checks++;
        if (cmem[0] !== 8'h88) begin
            errors++;
            $display("FAIL bad_size_no_write: mem[0]=%h, required 88", cmem[0]);
        end
    endtask

    task automatic test_stall();
        res_t r;
        run(1, 1'b0, 64'h8000_0000, 4'd4, 64'h0, 3, r);
        checks++;
        if (!r.ok || r.lat != 5) begin
            errors++;
            $display("FAIL stall_latency: ok=%0d lat=%0d, required 5", r.ok, r.lat);
        end
        checks++;
        if (!r.stable || !r.rdy_low || r.rd !== 64'h55667788 || r.er !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: stable=%0d rdy_low=%0d rdata=%h err=%b, required 1 1 55667788 0",
                     r.stable, r.rdy_low, r.rd, r.er);
        end
        checks++;
        if (r.rdy_after !== 1'b1 || r.vld_after !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rdy=%b vld=%b, required rdy 1 vld 0", r.rdy_after, r.vld_after);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, hs = 0, c0, busy_bad = 0, hs_cyc = -1;
        int acc_cyc [2];
        bit inflight = 1'b0;
        bit a, h;
        acc_cyc[0] = -1; acc_cyc[1] = -1;
        sel = 1;
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 64'h8000_0000;
        req_len = 4'd8; rsp_ready = 1'b1;
        c0 = dpi_calls;
        for (int cyc = 0; cyc < 60 && hs < 2; cyc++) begin
            if (busy_a[1] !== inflight) busy_bad++;
            a = req_valid && rdy_a[1];
            h = vld_a[1] && rsp_ready;
            @(posedge clock);
            if (h) begin hs++; inflight = 1'b0; if (hs == 1) hs_cyc = cyc; end
            if (a) begin if (acc < 2) acc_cyc[acc] = cyc; acc++; inflight = 1'b1; end
            @(negedge clock);
            if (acc >= 2) req_valid = 1'b0;
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        checks++;
        if (acc != 2 || hs != 2 || dpi_calls - c0 != 2) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d handshakes=%0d calls=%0d, required 2 2 2",
                     acc, hs, dpi_calls - c0);
        end
        checks++;
        if (acc_cyc[1] - hs_cyc != 1 || acc_cyc[1] - acc_cyc[0] != 6) begin
            errors++;
            $display("FAIL b2b_spacing: accept gap=%0d after_hs=%0d, required 6 and 1",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[1] - hs_cyc);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL b2b_busy: %0d cycles with wrong busy, required 0", busy_bad);
        end
    endtask

    task automatic test_reset_mid_wait();
        res_t r;
        int seen = 0;
        sel = 2;
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 64'h8000_0008; req_len = 4'd4;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && !rdy_a[2]; n++) @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({rdy_a[2], vld_a[2], err_a[2], busy_a[2]} !== 4'b0000 || rdata_a[2] !== 64'd0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b err=%b busy=%b rdata=%h, required all 0",
                     rdy_a[2], vld_a[2], err_a[2], busy_a[2], rdata_a[2]);
        end
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (vld_a[2] !== 1'b0 || rdy_a[2] !== 1'b1) seen++;
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_dropped: %0d cycles with response or not ready, required 0", seen);
        end
        run(2, 1'b0, 64'h8000_0000, 4'd8, 64'h0, 1, r);
        checks++;
        if (!r.ok || r.lat != 4 || r.rd !== ref_read(64'h8000_0000, 8) || r.er !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: ok=%0d lat=%0d rdata=%h err=%b, required lat 4 rdata %h err 0",
                     r.ok, r.lat, r.rd, r.er, ref_read(64'h8000_0000, 8));
        end
    endtask

    task automatic test_random();
        res_t r;
        int lens [7] = '{1, 2, 4, 8, 3, 0, 6};
        int lats [3] = '{1, 5, 4};
        for (int i = 0; i < 40; i++) begin
            int g, len;
            bit rw, e;
            logic [63:0] a, wd, exp_rd;
            g   = int'($urandom_range(0, 2));
            len = lens[$urandom_range(0, 6)];
            rw  = 1'($urandom_range(0, 1));
            a   = 64'h8000_0000 + 64'($urandom_range(0, 240));
            if ($urandom_range(0, 1) == 1 && len > 0) a = a - (a % 64'(len));
            wd  = {$urandom, $urandom};
            e   = ref_err(a, len);
            exp_rd = (e || rw) ? 64'd0 : ref_read(a, len);
            if (rw && !e) ref_write(a, len, wd);
            run(g, rw, a, 4'(len), wd, int'($urandom_range(0, 2)), r);
            checks++;
            if (!r.ok || r.lat != lats[g] || r.er !== e || r.rd !== exp_rd || r.calls != (e ? 0 : 1)) begin
                errors++;
                $display("FAIL random[%0d] port%0d rw=%0d addr=%h len=%0d: lat=%0d err=%b rdata=%h calls=%0d, required lat=%0d err=%b rdata=%h calls=%0d",
                         i, g, rw, a, len, r.lat, r.er, r.rd, r.calls,
                         lats[g], e, exp_rd, e ? 0 : 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) cmem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_narrow_read();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_hs.md
Name: mem_port_hs

Overview:
- Parametrised successor to the free-running DPI memory port.
- Valid/ready request and response channels replace the sensitivity-triggered access.
- Programmable access latency, size/alignment checking and an error response.
- Sits between the LSU/IFU and the C-side simulated memory, reached through the DPI-C call vmem_access.

Parameters:
ADDR_W, 64, request address width.
DATA_W, 64, data width in bits; must be 32 or 64.
LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..15.
ALIGN_CHECK, 1, 1 = misaligned access returns an error; 0 = passed to DPI unchecked.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous reset, active-low.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
req_rw  in  1  0 = read, 1 = write.
req_addr  in  ADDR_W  byte address.
req_len  in  4  access size in bytes: 1, 2, 4 or 8 (8 legal only if DATA_W = 64).
req_wdata  in  DATA_W  write data, right-justified; only the low req_len bytes are used.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge.
rsp_rdata  out  DATA_W  read data, right-justified and zero-extended; 0 for writes and errors.
rsp_err  out  1  1 = illegal size or misaligned access.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state = IDLE, counter = 0.
  - req_ready = 1 (reset value 0 while reset is asserted).
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Reset mid-operation drops the transaction: no response is issued. A DPI write already issued is not undone.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch rw, addr, len and wdata, then decode:
    - err_size = len not in {1, 2, 4, 8}, or len = 8 with DATA_W = 32.
    - err_align = ALIGN_CHECK & ((addr & (len - 1)) != 0), evaluated only when err_size = 0.
  - No error: call vmem_access(rw, addr, len, wdata, rdata) exactly once, in the accept-edge always block. Mask rdata to len bytes, zero-extend and latch it.
  - Error: no DPI call; latch rdata = 0 and err = 1.
  - Load counter = LATENCY - 1.
  - Next state = RESP if LATENCY = 1, otherwise WAIT.
- WAIT:
  - req_ready = 0.
  - Decrement counter each cycle; move to RESP when counter = 1 (on that edge).
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the handshake; req_ready = 0.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid = 0 the next cycle.
  - No request/response overlap: the earliest next accept is the cycle after the response handshake. Throughput is at most 1 request per LATENCY + 1 cycles.
- Request inputs are ignored when req_ready = 0. A request held valid across a busy period is accepted once, on the first IDLE edge.
- busy = (state != IDLE).
- DPI is never called on cycles without an accept (no sensitivity-list calls, no calls during reset).
- The single outstanding transaction means no ordering hazards. A write followed by a read to the same address returns the written data.

Test Plan:
1. Reset, LATENCY = 1:
   - Write addr 0x80000000, len 8, wdata 0x1122334455667788.
   - Then read the same address, len 8.
   - Expect rsp_valid 1 cycle after each accept, err = 0, read rdata = 0x1122334455667788.
2. Byte read at addr 0x80000003, len 1, after test 1 (little-endian backing store):
   - Expect rdata = 0x0000000000000055, err = 0.
   - The read at addr 0x80000004, len 2 returns 0x0000000000003344.
3. Misaligned word and illegal size:
   - Read addr 0x80000002, len 4 with ALIGN_CHECK = 1 -> rsp_err = 1, rdata = 0, zero DPI calls (checked by C-side counter).
   - len = 3 -> rsp_err = 1, zero DPI calls.
4. LATENCY = 5, rsp_ready held 0 for 3 cycles after rsp_valid:
   - rsp_valid rises 5 cycles after the accept edge.
   - rdata stays stable while stalled; req_ready stays 0 through WAIT and RESP.
   - req_ready returns to 1 the cycle after the handshake.
5. Back-to-back requests with req_valid held high:
   - Exactly one DPI call per accepted request.
   - The second accept occurs the cycle after the first response handshake; busy toggles accordingly.
6. reset driven low during WAIT (LATENCY = 4, second wait cycle), released one cycle later:
   - No rsp_valid for the dropped request; all outputs at their reset values.
   - A fresh read completes normally with LATENCY timing.
